logic_accum: RTL and testbench
==============================

# logic_accum

Parametrised, registered successor to the team's combinational two-input gate. It applies one of eight bitwise logic operations to WIDTH-bit operands under a valid/ready handshake. It also offers an accumulate mode that folds a multi-beat burst into a single result. It sits between a stimulus/bus source and a result consumer, with one-cycle registered latency and full throughput.

## Interface
- WIDTH, 8, operand/result width (≥1)
- MAX_BEATS, 16, beat-count saturation limit for accumulate bursts (≥2); CW = $clog2(MAX_BEATS+1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (used on first beat only in accumulate mode)
- in_op  in  3  operation: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS_A, 7 NOT_A
- in_mode  in  1  0 pairwise, 1 accumulate
- in_last  in  1  final beat of accumulate burst (ignored in pairwise)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_y  out  WIDTH  result
- out_zero  out  1  out_y == 0
- out_count  out  CW  beats folded into out_y, saturating at MAX_BEATS
- out_ovf  out  1  burst exceeded MAX_BEATS beats

## Operation
- FSM states: IDLE, ACCUM. The output register (out_valid) is independent of the FSM.
- in_ready = !out_valid | out_ready, combinational. No other stall source.
- Pairwise beat (IDLE, in_mode=0): out_y ← op(in_a,in_b), out_count ← 1, out_ovf ← 0, out_valid ← 1.
- Accumulate first beat (IDLE, in_mode=1):
  - acc ← op(in_a,in_b), cnt ← 1.
  - in_op is latched for the burst.
  - If in_last, the result is emitted immediately as in pairwise; otherwise go to ACCUM.
- ACCUM beat:
  - acc ← op_latched(acc,in_a), with cnt incremented and saturating at MAX_BEATS.
  - ovf is sticky, set when a beat arrives with cnt==MAX_BEATS.
  - in_op, in_mode and in_b are ignored.
  - On in_last: out_y ← new acc, out_count ← cnt, out_ovf ← ovf, out_valid ← 1, and return to IDLE.
- Non-last ACCUM beats do not touch out_* registers.
- out_zero is registered together with out_y.
- out_valid clears on out_valid & out_ready unless a result-producing beat is accepted in the same cycle.

## Timing
- Latency: one clock from accepted result-producing beat to out_valid.
- Throughput: one beat per clock. A pop and a new result load in the same cycle are legal and lose no data.
- out_* are stable while out_valid & !out_ready.
- Reset (asynchronous assert, synchronous deassert at the source) drives:
  - FSM to IDLE
  - out_valid=0, out_y=0, out_zero=0, out_count=0, out_ovf=0
  - acc=0, cnt=0, latched op=0
  - in_ready therefore reads 1.
- Reset mid-burst discards the partial accumulation. The next beat is treated as a first beat.
- A single-beat accumulate burst (first beat with in_last) yields out_count=1.
- Beats past MAX_BEATS are still folded into acc. Only the count saturates.

## Configuration
- LOGIC_ACCUM_PARITY_EN defined:
  - Adds output out_par (1 bit) = ^out_y, registered with out_y.
  - Reset value 0.
- Not defined: out_par and its logic are absent. All other behaviour is identical.

## Structure
- Package logic_accum_pkg holds:
  - the op_e enum (3-bit encoding above)
  - mode constants MODE_PAIR/MODE_ACC
  - state_e (IDLE, ACCUM)
  - function logic_op(op, x, y) returning the WIDTH-agnostic bitwise result
- Sub-module logic_op is natural: a combinational WIDTH-parametrised evaluator instantiated once. Its x input is muxed between in_a and acc.

## Test plan
- WIDTH=1, pairwise AND, (a,b) = 00, 01, 10, 11 at 10 ns spacing, out_ready=1 -> out_y 0, 0, 0, 1, each one cycle after acceptance, with out_count=1.
- WIDTH=8, pairwise AND 0xF0,0x3C -> out_y=0x30, out_zero=0. NAND 0xFF,0xFF -> out_y=0x00, out_zero=1. NOT_A 0x5A -> 0xA5.
- Accumulate XOR: beats (a=0x01,b=0x00), 0x02, 0x04 with in_last on the third -> one result, out_y=0x07, out_count=3, out_ovf=0. No out_valid before the third beat.
- Backpressure: hold out_ready=0 after a result -> in_ready=0, next beat stalls and out_y is held. Raise out_ready -> pop and new beat accepted in the same cycle, new result valid next cycle.
- MAX_BEATS=4, OR burst of 6 beats 0x01, 0x02, 0x04, 0x08, 0x10, 0x20 -> out_y=0x3F, out_count=4, out_ovf=1. A following pairwise beat -> out_ovf=0.
- Reset asserted after 2 of 3 accumulate beats -> all outputs 0 immediately. A new single-beat burst AND 0x0F,0xFF with in_last -> out_y=0x0F, out_count=1. With LOGIC_ACCUM_PARITY_EN, out_par=0.

Source files
------------

// File: rtl/logic_accum_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : logic_accum_pkg                                              |
// | Description : Shared types and the per-bit logic operation for logic_accum |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package logic_accum_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_PASS_A = 3'd6,
        OP_NOT_A  = 3'd7
    } op_e;

    localparam logic MODE_PAIR = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Single-bit evaluator; wider operands apply it bit by bit.
    function automatic logic logic_op(op_e op, logic x, logic y);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:    r = x & y;
            OP_OR:     r = x | y;
            OP_XOR:    r = x ^ y;
            OP_NAND:   r = ~(x & y);
            OP_NOR:    r = ~(x | y);
            OP_XNOR:   r = ~(x ^ y);
            OP_PASS_A: r = x;
            OP_NOT_A:  r = ~x;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/logic_accum_if.sv
// +----------------------------------------------------------------------------+
// | Module      : logic_accum_if                                               |
// | Description : Input-beat and result handshake bundle for logic_accum.      |
// |               out_par exists only when LOGIC_ACCUM_PARITY_EN is defined.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface logic_accum_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
);
    import logic_accum_pkg::*;

    localparam int CW = $clog2(MAX_BEATS + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_e              in_op;
    logic             in_mode;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic [CW-1:0]    out_count;
    logic             out_ovf;
`ifdef LOGIC_ACCUM_PARITY_EN
    logic             out_par;
`endif

    modport master (
        output in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
`ifdef LOGIC_ACCUM_PARITY_EN
        input  out_par,
`endif
        input  in_ready, out_valid, out_y, out_zero, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_mode, in_last, out_ready,
`ifdef LOGIC_ACCUM_PARITY_EN
        output out_par,
`endif
        output in_ready, out_valid, out_y, out_zero, out_count, out_ovf
    );

endinterface

`default_nettype wire

// File: rtl/logic_accum_op.sv
// +----------------------------------------------------------------------------+
// | Module      : logic_accum_op                                               |
// | Description : Combinational WIDTH-bit bitwise logic evaluator              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module logic_accum_op
    import logic_accum_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign res[i] = logic_op(op, x[i], y[i]);
    end

endmodule

`default_nettype wire

// File: rtl/logic_accum.sv
// +----------------------------------------------------------------------------+
// | Module      : logic_accum                                                  |
// | Description : Registered bitwise logic unit with pairwise and burst-       |
// |               accumulate modes. LOGIC_ACCUM_PARITY_EN adds out_par.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module logic_accum
    import logic_accum_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    logic_accum_if.slave  bus
);

    localparam int            CW    = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_BEATS);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    op_e              r_op;
    op_e              w_op_nxt;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_load;
    logic [CW-1:0]    w_load_cnt;
    logic             w_load_ovf;

    op_e              w_eval_op;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic [WIDTH-1:0] w_res;

    logic             r_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic [CW-1:0]    r_count;
    logic             r_out_ovf;

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Inside a burst the running value is folded with each new in_a.
    assign w_eval_op = (r_state == ACCUM) ? r_op  : bus.in_op;
    assign w_x       = (r_state == ACCUM) ? r_acc : bus.in_a;
    assign w_y       = (r_state == ACCUM) ? bus.in_a : bus.in_b;

    logic_accum_op #(.WIDTH(WIDTH)) u_op (
        .op  (w_eval_op),
        .x   (w_x),
        .y   (w_y),
        .res (w_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_op_nxt    = r_op;
        w_load      = 1'b0;
        w_load_cnt  = C_ONE;
        w_load_ovf  = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (bus.in_mode == MODE_ACC) begin
                        w_acc_nxt = w_res;
                        w_cnt_nxt = C_ONE;
                        w_ovf_nxt = 1'b0;
                        w_op_nxt  = bus.in_op;
                        if (bus.in_last) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = ACCUM;
                        end
                    end else begin
                        w_load = 1'b1;
                    end
                end
                ACCUM: begin
                    w_acc_nxt = w_res;
                    w_cnt_nxt = (r_cnt == C_MAX) ? r_cnt : r_cnt + C_ONE;
                    w_ovf_nxt = r_ovf || (r_cnt == C_MAX);
                    if (bus.in_last) begin
                        w_load      = 1'b1;
                        w_load_cnt  = w_cnt_nxt;
                        w_load_ovf  = w_ovf_nxt;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_op  <= OP_AND;
        end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
            r_op  <= w_op_nxt;
        end
    end

    // A new result wins over a same-cycle pop, so back-to-back results never drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_y       <= '0;
            r_zero    <= 1'b0;
            r_count   <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_y       <= w_res;
            r_zero    <= (w_res == '0);
            r_count   <= w_load_cnt;
            r_out_ovf <= w_load_ovf;
        end else if (r_valid && bus.out_ready) begin
            r_valid   <= 1'b0;
        end
    end

`ifdef LOGIC_ACCUM_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= ^w_res;
        end
    end

    assign bus.out_par = r_par;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_y     = r_y;
    assign bus.out_zero  = r_zero;
    assign bus.out_count = r_count;
    assign bus.out_ovf   = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_logic_accum.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_logic_accum                                               |
// | Description : Self-checking bench for logic_accum (WIDTH=1 and WIDTH=8)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_logic_accum;
    import logic_accum_pkg::*;

    localparam int MB1 = 16;
    localparam int MB8 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_accum_if #(.WIDTH(1), .MAX_BEATS(MB1)) b1 ();
    logic_accum_if #(.WIDTH(8), .MAX_BEATS(MB8)) b8 ();

    logic_accum #(.WIDTH(1), .MAX_BEATS(MB1)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    logic_accum #(.WIDTH(8), .MAX_BEATS(MB8)) u_w8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        op_e        op;
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        logic [7:0] y;
        logic       zero;
    } vec_t;
    vec_t tbl [10];

    // Reference model state for the randomized section
    logic       m_valid;
    logic [7:0] m_y;
    int         m_cnt;
    logic       m_ovf;
    logic [7:0] bq [$];
    op_e        b_op;
    logic [7:0] b_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_op(op_e op, logic [7:0] x, logic [7:0] y);
        case (op)
            OP_AND:    return x & y;
            OP_OR:     return x | y;
            OP_XOR:    return x ^ y;
            OP_NAND:   return ~(x & y);
            OP_NOR:    return ~(x | y);
            OP_XNOR:   return ~(x ^ y);
            OP_PASS_A: return x;
            default:   return ~x;
        endcase
    endfunction

    task automatic drive8(input logic v, input op_e op, input logic [7:0] a, input logic [7:0] b,
                          input logic mode, input logic last);
        b8.in_valid = v;
        b8.in_op    = op;
        b8.in_a     = a;
        b8.in_b     = b;
        b8.in_mode  = mode;
        b8.in_last  = last;
    endtask

    task automatic beat8(input op_e op, input logic [7:0] a, input logic [7:0] b,
                         input logic mode, input logic last);
        drive8(1'b1, op, a, b, mode, last);
        tick();
        b8.in_valid = 1'b0;
    endtask

    task automatic chk_out8(input string tag, input logic v, input logic [7:0] y, input logic z,
                            input int cnt, input logic ovf);
        chk({tag, ".valid"}, 64'(b8.out_valid), 64'(v));
        chk({tag, ".y"},     64'(b8.out_y),     64'(y));
        chk({tag, ".zero"},  64'(b8.out_zero),  64'(z));
        chk({tag, ".count"}, 64'(b8.out_count), 64'(cnt));
        chk({tag, ".ovf"},   64'(b8.out_ovf),   64'(ovf));
`ifdef LOGIC_ACCUM_PARITY_EN
        chk({tag, ".par"},   64'(b8.out_par),   64'(v ? ^y : 1'b0));
`endif
    endtask

    initial begin
        logic       v, rdy, md, lst, exp_rdy, produce, p_ovf;
        op_e        op;
        logic [7:0] a, b, p_y;
        int         p_cnt;

        b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.in_op = OP_AND;
        b1.in_mode = MODE_PAIR; b1.in_last = 1'b0; b1.out_ready = 1'b1;
        drive8(1'b0, OP_AND, 8'h00, 8'h00, MODE_PAIR, 1'b0);
        b8.out_ready = 1'b1;

        tbl[0] = '{OP_AND,    8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0};
        tbl[1] = '{OP_NAND,   8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{OP_NOT_A,  8'h5A, 8'h00, 1'b0, 8'hA5, 1'b0};
        tbl[3] = '{OP_OR,     8'h0A, 8'h50, 1'b0, 8'h5A, 1'b0};
        tbl[4] = '{OP_XOR,    8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0};
        tbl[5] = '{OP_NOR,    8'h0F, 8'hF0, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{OP_XNOR,   8'h3C, 8'h0F, 1'b0, 8'hCC, 1'b0};
        tbl[7] = '{OP_PASS_A, 8'h77, 8'h11, 1'b0, 8'h77, 1'b0};
        tbl[8] = '{OP_AND,    8'h0F, 8'hFF, 1'b1, 8'h0F, 1'b0};
        tbl[9] = '{OP_XOR,    8'hAA, 8'hAA, 1'b1, 8'h00, 1'b1};

        // Reset state
        #12;
        chk_out8("rst", 1'b0, 8'h00, 1'b0, 0, 1'b0);
        chk("rst.in_ready8", 64'(b8.in_ready), 64'(1));
        chk("rst.valid1", 64'(b1.out_valid), 64'(0));
        chk("rst.in_ready1", 64'(b1.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // WIDTH=1 AND truth table, back to back
        for (int i = 0; i < 4; i++) begin
            b1.in_valid = 1'b1;
            b1.in_a     = 1'(i >> 1);
            b1.in_b     = 1'(i);
            tick();
            chk("w1.valid", 64'(b1.out_valid), 64'(1));
            chk("w1.y",     64'(b1.out_y),     64'(i == 3));
            chk("w1.count", 64'(b1.out_count), 64'(1));
        end
        b1.in_valid = 1'b0;

        // WIDTH=8 pairwise and single-beat accumulate vectors
        for (int i = 0; i < 10; i++) begin
            beat8(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].mode);
            chk_out8($sformatf("tbl%0d", i), 1'b1, tbl[i].y, tbl[i].zero, 1, 1'b0);
        end

        // XOR burst; later beats carry junk op/mode/b that must be ignored
        beat8(OP_XOR, 8'h01, 8'h00, MODE_ACC, 1'b0);
        chk("xacc.b1.valid", 64'(b8.out_valid), 64'(0));
        beat8(OP_AND, 8'h02, 8'hFF, MODE_PAIR, 1'b0);
        chk("xacc.b2.valid", 64'(b8.out_valid), 64'(0));
        beat8(OP_AND, 8'h04, 8'hFF, MODE_PAIR, 1'b1);
        chk_out8("xacc", 1'b1, 8'h07, 1'b0, 3, 1'b0);

        // Backpressure: stall, hold, then pop and load in one cycle
        beat8(OP_AND, 8'hFF, 8'h0F, MODE_PAIR, 1'b0);
        b8.out_ready = 1'b0;
        #1;
        chk("bp.in_ready0", 64'(b8.in_ready), 64'(0));
        drive8(1'b1, OP_OR, 8'h10, 8'h01, MODE_PAIR, 1'b0);
        tick();
        tick();
        chk_out8("bp.hold", 1'b1, 8'h0F, 1'b0, 1, 1'b0);
        b8.out_ready = 1'b1;
        #1;
        chk("bp.in_ready1", 64'(b8.in_ready), 64'(1));
        tick();
        b8.in_valid = 1'b0;
        chk_out8("bp.new", 1'b1, 8'h11, 1'b0, 1, 1'b0);
        tick();
        chk("bp.drain", 64'(b8.out_valid), 64'(0));

        // Exactly MAX_BEATS beats: saturated count, no overflow
        for (int i = 0; i < 4; i++) begin
            beat8(OP_OR, 8'(1 << i), 8'h00, MODE_ACC, i == 3);
        end
        chk_out8("max4", 1'b1, 8'h0F, 1'b0, 4, 1'b0);

        // Six-beat burst overflows; next pairwise result clears ovf
        for (int i = 0; i < 6; i++) begin
            beat8(OP_OR, 8'(1 << i), 8'h00, MODE_ACC, i == 5);
            if (i < 5) chk("ovf6.pending", 64'(b8.out_valid), 64'(0));
        end
        chk_out8("ovf6", 1'b1, 8'h3F, 1'b0, 4, 1'b1);
        beat8(OP_AND, 8'hFF, 8'hFF, MODE_PAIR, 1'b0);
        chk_out8("ovf.clr", 1'b1, 8'hFF, 1'b0, 1, 1'b0);

        // Reset in the middle of a burst
        beat8(OP_XOR, 8'h01, 8'h00, MODE_ACC, 1'b0);
        beat8(OP_XOR, 8'h02, 8'h00, MODE_ACC, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_out8("midrst", 1'b0, 8'h00, 1'b0, 0, 1'b0);
        chk("midrst.in_ready", 64'(b8.in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        beat8(OP_AND, 8'h0F, 8'hFF, MODE_ACC, 1'b1);
        chk_out8("postrst", 1'b1, 8'h0F, 1'b0, 1, 1'b0);
        tick();

        // Randomized traffic against the burst-level model
        m_valid = 1'b0;
        m_y     = 8'h00;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        bq.delete();
        for (int c = 0; c < 600; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            op  = op_e'($urandom_range(0, 7));
            a   = 8'($urandom);
            b   = 8'($urandom);
            md  = 1'($urandom_range(0, 1));
            lst = ($urandom_range(0, 2) == 0);
            drive8(v, op, a, b, md, lst);
            b8.out_ready = rdy;
            #1;
            exp_rdy = !m_valid || rdy;
            chk("rnd.in_ready", 64'(b8.in_ready), 64'(exp_rdy));
            produce = 1'b0;
            p_y     = 8'h00;
            p_cnt   = 0;
            p_ovf   = 1'b0;
            if (v && exp_rdy) begin
                if (bq.size() == 0 && md == MODE_PAIR) begin
                    produce = 1'b1;
                    p_y     = ref_op(op, a, b);
                    p_cnt   = 1;
                end else begin
                    if (bq.size() == 0) begin
                        b_op = op;
                        b_b  = b;
                    end
                    bq.push_back(a);
                    if (lst) begin
                        p_y = ref_op(b_op, bq[0], b_b);
                        for (int k = 1; k < bq.size(); k++) p_y = ref_op(b_op, p_y, bq[k]);
                        p_cnt   = (bq.size() > MB8) ? MB8 : bq.size();
                        p_ovf   = (bq.size() > MB8);
                        produce = 1'b1;
                        bq.delete();
                    end
                end
            end
            if (produce) begin
                m_valid = 1'b1;
                m_y     = p_y;
                m_cnt   = p_cnt;
                m_ovf   = p_ovf;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            tick();
            if (m_valid) begin
                chk_out8("rnd", 1'b1, m_y, (m_y == 8'h00), m_cnt, m_ovf);
            end else begin
                chk("rnd.valid", 64'(b8.out_valid), 64'(0));
            end
        end
        b8.in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
